// File: rtl/key_pkg.sv
// key_pkg: shared constants, event type and helpers for the key event queue
package key_pkg;
   localparam int FIFO_DEPTH = 4;
   localparam int KEY_IDX_W = 3;
   localparam int STABLE_CNT = 4;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   typedef enum logic {EV_PRESS = 1'b0, EV_RELEASE = 1'b1} ev_type_t;
   typedef struct packed {
      ev_type_t typ;
      logic [KEY_IDX_W-1:0] idx;
   } ev_entry_t;
   function automatic logic [KEY_IDX_W-1:0] lowest_idx(input logic [7:0] v);
      lowest_idx = '0;
      for (int i = 7; i >= 0; i--) if (v[i]) lowest_idx = KEY_IDX_W'(i);
   endfunction
   function automatic logic multi_hot(input logic [7:0] v);
      return (v & (v - 8'd1)) != 8'd0;
   endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, tick-sampled stability counter and edge outputs for one key
module key_debounce
   import key_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic rise,
   output logic fall
);
   localparam int RUN_W = $clog2(STABLE_CNT);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT - 1);
   logic s1, s2, level, level_d;
   logic [RUN_W-1:0] run;
   // level flips only after STABLE_CNT consecutive differing tick samples
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         level <= 1'b0;
         level_d <= 1'b0;
         run <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         level_d <= level;
         if (tick) begin
            if (s2 == level) run <= '0;
            else if (run == RUN_MAX) begin
               run <= '0;
               level <= ~level;
            end else run <= run + 1'b1;
         end
      end
   assign rise = level & ~level_d;
   assign fall = ~level & level_d;
endmodule

// File: rtl/tt_um_key_jellyant.sv
// tt_um_key_jellyant: debounced 8-key event queue; release events enabled by macro KEY_RELEASE_EN
module tt_um_key_jellyant
   import key_pkg::*;
#(
   parameter int DEBOUNCE_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   localparam logic [15:0] PC_MAX = 16'(DEBOUNCE_DIV - 1);
   logic [15:0] pc;
   logic tick;
   logic [7:0] rise, fall, ev;
   logic p_s1, p_s2, p_d, c_s1, c_s2;
   logic [3:0] mem [FIFO_DEPTH];
   logic [3:0] head;
   logic [PTR_W:0] wp, rp;
   logic empty, full, pop, push_req, push, set_ovf, ovf;
   logic [7:0] presses;
   ev_entry_t ent;
   logic unused;
   assign tick = pc == PC_MAX;
   // free-running sample prescaler
   always_ff @(posedge clk or posedge rst)
      if (rst) pc <= '0;
      else pc <= tick ? '0 : pc + 16'd1;
   for (genvar k = 0; k < 8; k++) begin : g_db
      key_debounce u_db (
         .clk (clk),
         .rst (rst),
         .tick(tick),
         .raw (ui_in[k]),
         .rise(rise[k]),
         .fall(fall[k])
      );
   end
`ifdef KEY_RELEASE_EN
   assign ev = rise | fall;
   assign ent = |rise ? ev_entry_t'{typ: EV_PRESS, idx: lowest_idx(rise)}
                      : ev_entry_t'{typ: EV_RELEASE, idx: lowest_idx(fall)};
   assign uo_out = {~empty, ovf, 2'b00, empty ? 4'h0 : head};
`else
   assign ev = rise;
   assign ent = ev_entry_t'{typ: EV_PRESS, idx: lowest_idx(rise)};
   assign uo_out = {~empty, ovf, 3'b000, empty ? 3'h0 : head[2:0]};
`endif
   assign head = mem[rp[PTR_W-1:0]];
   assign empty = wp == rp;
   assign full = (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
   assign pop = p_s2 & ~p_d & ~empty;
   assign push_req = |ev;
   assign push = push_req & (~full | pop);
   assign set_ovf = multi_hot(ev) | (push_req & full & ~pop);
   // pointers, control synchronisers, sticky overflow and press counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         p_s1 <= 1'b0;
         p_s2 <= 1'b0;
         p_d <= 1'b0;
         c_s1 <= 1'b0;
         c_s2 <= 1'b0;
         ovf <= 1'b0;
         presses <= '0;
      end else begin
         p_s1 <= uio_in[0];
         p_s2 <= p_s1;
         p_d <= p_s2;
         c_s1 <= uio_in[1];
         c_s2 <= c_s1;
         ovf <= set_ovf | (ovf & ~c_s2);
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (push && ent.typ == EV_PRESS) presses <= presses + 8'd1;
      end
   // queue storage needs no reset: pointers define validity
   always_ff @(posedge clk)
      if (push) mem[wp[PTR_W-1:0]] <= ent;
   assign uio_out = {presses[3:0], 4'h0};
   assign uio_oe = 8'hF0;
   assign unused = &{1'b0, ena, uio_in[7:2], presses[7:4], fall, head[3]};
endmodule

// File: tb/tb_tt_um_key_jellyant.sv
// tb_tt_um_key_jellyant: randomized and directed bench against a behavioural key-queue model
module tb_tt_um_key_jellyant;
   localparam int DIV = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;
   int errors = 0;
   int checks = 0;

   tt_um_key_jellyant #(.DEBOUNCE_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // behavioural model: inputs seen through 2-cycle delays, debounced by counting tick samples
   int m_pc = 0;
   logic [7:0] m_ud1 = 0, m_ud2 = 0, m_lvl = 0, m_lvl_prev = 0;
   int m_run[8] = '{default: 0};
   logic m_p1 = 0, m_p2 = 0, m_p3 = 0, m_c1 = 0, m_c2 = 0, m_ovf = 0;
   logic [3:0] m_q[$];
   logic [7:0] m_presses = 0;
   logic [7:0] m_rise, m_ev, m_fall_ev;
   logic [3:0] m_ent;
   logic m_found, m_pop, m_set, m_push;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 0; m_ud1 = 0; m_ud2 = 0; m_lvl = 0; m_lvl_prev = 0;
         for (int i = 0; i < 8; i++) m_run[i] = 0;
         m_p1 = 0; m_p2 = 0; m_p3 = 0; m_c1 = 0; m_c2 = 0; m_ovf = 0;
         m_q.delete();
         m_presses = 0;
      end else begin
         m_rise = m_lvl & ~m_lvl_prev;
`ifdef KEY_RELEASE_EN
         m_ev = m_rise | (~m_lvl & m_lvl_prev);
`else
         m_ev = m_rise;
`endif
         m_fall_ev = m_ev & ~m_rise;
         m_pop = m_p2 && !m_p3 && m_q.size() > 0;
         m_set = 0;
         m_push = 0;
         m_ent = 0;
         m_found = 0;
         for (int i = 0; i < 8; i++)
            if (!m_found && m_rise[i]) begin m_ent = {1'b0, 3'(i)}; m_found = 1; end
         for (int i = 0; i < 8; i++)
            if (!m_found && m_fall_ev[i]) begin m_ent = {1'b1, 3'(i)}; m_found = 1; end
         if (m_ev != 0) begin
            if ($countones(m_ev) > 1) m_set = 1;
            if (m_q.size() == 4 && !m_pop) m_set = 1;
            else m_push = 1;
         end
         if (m_pop) void'(m_q.pop_front());
         if (m_push) begin
            m_q.push_back(m_ent);
            if (!m_ent[3]) m_presses++;
         end
         m_ovf = m_set ? 1'b1 : (m_c2 ? 1'b0 : m_ovf);
         m_lvl_prev = m_lvl;
         if (m_pc == DIV - 1)
            for (int i = 0; i < 8; i++) begin
               if (m_ud2[i] != m_lvl[i]) begin
                  m_run[i]++;
                  if (m_run[i] == 4) begin m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; end
               end else m_run[i] = 0;
            end
         m_pc = (m_pc + 1) % DIV;
         m_ud2 = m_ud1; m_ud1 = ui_in;
         m_p3 = m_p2; m_p2 = m_p1; m_p1 = uio_in[0];
         m_c2 = m_c1; m_c1 = uio_in[1];
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("uo_out_model", uo_out, {m_q.size() > 0, m_ovf, 2'b00, m_q.size() > 0 ? m_q[0] : 4'h0});
      chk("uio_out_model", uio_out, {m_presses[3:0], 4'h0});
      chk("uio_oe_model", uio_oe, 8'hF0);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      ui_in = 8'h00;
      uio_in = 8'h00;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic pop_pulse();
      uio_in[0] = 1'b1;
      cyc(3);
      uio_in[0] = 1'b0;
      cyc(3);
   endtask

   initial begin
      #1 rst = 1'b1;
      cyc(2);
      chk("reset_uo", uo_out, 8'h00);
      chk("reset_uio", uio_out, 8'h00);
      chk("reset_oe", uio_oe, 8'hF0);
      rst = 1'b0;

      ui_in[5] = 1'b1;
      cyc(40);
      chk("single_press_uo", uo_out, 8'h85);
      chk("single_press_uio", uio_out, 8'h10);

      do_reset();
      for (int r = 0; r < 4; r++) begin
         ui_in[2] = 1'b1; cyc(10);
         ui_in[2] = 1'b0; cyc(2);
      end
      ui_in[2] = 1'b1;
      cyc(40);
      chk("glitch_uo", uo_out, 8'h82);
      chk("glitch_count", uio_out, 8'h10);

      do_reset();
      ui_in = 8'h42;
      cyc(40);
      chk("simul_uo", uo_out, 8'hC1);
      uio_in[1] = 1'b1;
      cyc(6);
      chk("ovf_clear_uo", uo_out, 8'h81);
      uio_in[1] = 1'b0;

      do_reset();
      for (int k = 0; k < 5; k++) begin
         ui_in[k] = 1'b1;
         cyc(30);
      end
      chk("full_uo", uo_out, 8'hC0);
      chk("full_count", uio_out, 8'h40);
      for (int k = 0; k < 4; k++) pop_pulse();
      chk("drained_uo", uo_out, 8'h40);

      do_reset();
      for (int k = 0; k < 3; k++) begin
         ui_in[k] = 1'b1;
         cyc(30);
      end
      chk("three_queued", uo_out, 8'h80);
      rst = 1'b1;
      #1;
      chk("midreset_uo", uo_out, 8'h00);
      chk("midreset_uio", uio_out, 8'h00);
      cyc(2);
      rst = 1'b0;
      cyc(40);
      chk("rereport_uo", uo_out, 8'hC0);
      chk("rereport_count", uio_out, 8'h10);

      do_reset();
      ui_in[3] = 1'b1;
      cyc(30);
      ui_in[3] = 1'b0;
      cyc(30);
      chk("rel_head", uo_out, 8'h83);
      pop_pulse();
`ifdef KEY_RELEASE_EN
      chk("rel_second", uo_out, 8'h8B);
`else
      chk("rel_second", uo_out, 8'h00);
`endif

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int k;
         @(negedge clk);
         #1;
         k = $urandom_range(0, 7);
         if ($urandom_range(0, 19) == 0) ui_in[k] = ~ui_in[k];
         if ($urandom_range(0, 5) == 0) uio_in[0] = ~uio_in[0];
         if ($urandom_range(0, 59) == 0) uio_in[1] = ~uio_in[1];
         uio_in[7:2] = 6'($urandom);
         if (c == 1500) begin
            rst = 1'b1;
            cyc(2);
            rst = 1'b0;
         end
      end
      cyc(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tt_um_key_jellyant.md
TT_UM_KEY_JELLYANT -- requirements
Module: tt_um_key_jellyant

Interface
REQ-001 Parameter DEBOUNCE_DIV, default 1000: clk cycles per debounce sample tick (range 2..65535).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high; no other reset exists.
REQ-004 ena  input  1  power-good indicator; functionally ignored, tied into an unused-signal reduction.
REQ-005 ui_in  input  8  raw key/switch levels, asynchronous, 1 = pressed.
REQ-006 uo_out  output  8  [7] FIFO non-empty, [6] overflow sticky, [5:4] 0, [3] head event type (release=1), [2:0] head key index.
REQ-007 uio_in  input  8  [0] pop strobe (level, rising edge acts), [1] overflow clear (level, high clears), [7:2] unused.
REQ-008 uio_out  output  8  [7:4] press counter low nibble, [3:0] 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 Prescaler counts 0..DEBOUNCE_DIV-1 and wraps; a one-cycle tick is asserted when it equals DEBOUNCE_DIV-1.
REQ-011 Each ui_in bit passes through a 2-FF synchronizer before any other use.
REQ-012 Per bit, the debounced level changes only after 4 consecutive ticks that sample the same synchronized value differing from the current debounced level; any matching sample restarts the count.
REQ-013 Press event = debounced 0->1; release event = debounced 1->0; both are evaluated in the cycle after a tick.
REQ-014 Per event cycle, exactly one event is pushed: the lowest-index press, else (macro on) the lowest-index release; every additional simultaneous event is dropped and sets overflow.
REQ-015 FIFO: 4 entries x 4 bits {type, index[2:0]}; head is visible combinationally on uo_out[3:0] when non-empty, else uo_out[3:0] = 0.
REQ-016 Pop = uio_in[0] rising edge, detected via a 2-FF synchronizer plus edge register; pop while empty is ignored.
REQ-017 Push while full with no simultaneous pop drops the event and sets overflow; push and pop in the same cycle both succeed, at any occupancy including full.
REQ-018 Overflow stays set until uio_in[1] (synchronized) is high; a clear and a set in the same cycle leave overflow set.
REQ-019 Press counter: 8 bits, increments by 1 per pushed press event only, wraps 255->0, not affected by drops.
REQ-020 Latency: a raw edge held stable appears on uo_out[7] within 2 + 4*DEBOUNCE_DIV + 2 cycles.

Reset
REQ-021 While rst is high: prescaler, synchronizers, debounced levels, stability counters, FIFO pointers, overflow and press counter are 0; uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hF0.
REQ-022 Reset asserted mid-operation discards all queued events immediately; keys held through reset release produce a press event after debouncing.

Configuration
REQ-023 Macro KEY_RELEASE_EN defined: release events are queued with type bit 1.
REQ-024 Macro undefined: release events are never generated, uo_out[3] is constant 0, and releases never set overflow.

Structure
REQ-025 Package key_pkg holds FIFO depth (4), key index width (3), debounce stable count (4), and an event-type enum {EV_PRESS=0, EV_RELEASE=1}.
REQ-026 One sub-module key_debounce (synchronizer + stability counter + edge outputs per bit), instantiated 8 times; prescaler, arbiter and FIFO live in the top.

Verification (DEBOUNCE_DIV=4)
REQ-027 Raise ui_in[5], hold 40 cycles -> uo_out = 8'h85, uio_out = 8'h10.
REQ-028 Raise ui_in[2], pulse at 4 ticks with 2-cycle glitches low -> event only after the final 4 stable ticks; one press counted.
REQ-029 Raise ui_in[1] and ui_in[6] in the same cycle -> single entry index 1, overflow set (uo_out = 8'hC1); uio_in[1] high -> uo_out[6] = 0.
REQ-030 Five presses with no pop -> 4 entries held, 5th dropped, overflow = 1, press counter = 4; four pops -> uo_out[7] = 0.
REQ-031 With KEY_RELEASE_EN: press then release ui_in[3] -> head 8'h83, after pop head 8'h8B; without macro, second entry never appears.
REQ-032 Assert rst with 3 queued entries -> next cycle uo_out = 8'h00, uio_out = 8'h00; held keys re-report after debouncing.
